// File: rtl/vx_fpu_rsp_arb_pkg.sv
// Shared types and sizing helpers for the FPU response arbiter.
// fflags_t packs the RISC-V exception flags with NV in the MSB and NX in the LSB.
package vx_fpu_rsp_arb_pkg;

  localparam int XLEN       = 32;
  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } fflags_t;

  // Selector bits appended to the tag; zero when there is nothing to select between.
  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  // Width for holding an index, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_fpu_rsp_arb_if.sv
// Bundle of the per-channel FPU response inputs and the merged response output.
// The slave side is the arbiter; the master side drives responses and consumes the output.
interface vx_fpu_rsp_arb_if
  import vx_fpu_rsp_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int NUM_LANES  = 1,
  parameter int TAG_WIDTH  = 1
) ();

  localparam int SEL_BITS      = sel_bits(NUM_INPUTS);
  localparam int TAG_OUT_WIDTH = TAG_WIDTH + SEL_BITS;

  logic [NUM_INPUTS-1:0]                           rsp_in_valid;
  logic [NUM_INPUTS-1:0][NUM_LANES-1:0][XLEN-1:0]  rsp_in_result;
  fflags_t [NUM_INPUTS-1:0][NUM_LANES-1:0]         rsp_in_fflags;
  logic [NUM_INPUTS-1:0]                           rsp_in_has_fflags;
  logic [NUM_INPUTS-1:0][TAG_WIDTH-1:0]            rsp_in_tag;
  logic [NUM_INPUTS-1:0]                           rsp_in_ready;

  logic                                            rsp_out_valid;
  logic [NUM_LANES-1:0][XLEN-1:0]                  rsp_out_result;
  fflags_t [NUM_LANES-1:0]                         rsp_out_fflags;
  logic                                            rsp_out_has_fflags;
  logic [TAG_OUT_WIDTH-1:0]                        rsp_out_tag;
  logic                                            rsp_out_ready;

  modport master (
    output rsp_in_valid, rsp_in_result, rsp_in_fflags, rsp_in_has_fflags, rsp_in_tag,
    input  rsp_in_ready,
    input  rsp_out_valid, rsp_out_result, rsp_out_fflags, rsp_out_has_fflags, rsp_out_tag,
    output rsp_out_ready
  );

  modport slave (
    input  rsp_in_valid, rsp_in_result, rsp_in_fflags, rsp_in_has_fflags, rsp_in_tag,
    output rsp_in_ready,
    output rsp_out_valid, rsp_out_result, rsp_out_fflags, rsp_out_has_fflags, rsp_out_tag,
    input  rsp_out_ready
  );

endinterface

// File: rtl/vx_fpu_rsp_arb_rr_arbiter.sv
// Round-robin arbiter: the lowest requester at or after the pointer wins, wrapping around.
// The pointer moves past the winner only when a grant is actually issued.
module VX_rr_arbiter
  import vx_fpu_rsp_arb_pkg::*;
#(
  parameter  int NUM_REQS = 2,
  localparam int IDX_W    = idx_width(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] i_requests,
  input  logic                i_enable,
  output logic [NUM_REQS-1:0] o_grant_onehot,
  output logic [IDX_W-1:0]    o_grant_index,
  output logic                o_grant_valid
);

  logic [IDX_W-1:0]    r_ptr;
  logic [NUM_REQS-1:0] w_masked;

  always_comb begin
    w_masked = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_masked[i] = i_requests[i] && (i >= int'(r_ptr));
    end
  end

  // Requests at or above the pointer take priority; otherwise wrap to the bottom.
  always_comb begin
    o_grant_index  = '0;
    o_grant_valid  = 1'b0;
    o_grant_onehot = '0;
    if (i_enable) begin
      o_grant_valid = |i_requests;
      if (|w_masked) begin
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
          if (w_masked[i]) o_grant_index = IDX_W'(i);
        end
      end else begin
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
          if (i_requests[i]) o_grant_index = IDX_W'(i);
        end
      end
    end
    for (int i = 0; i < NUM_REQS; i++) begin
      o_grant_onehot[i] = o_grant_valid && (o_grant_index == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (o_grant_valid) begin
      r_ptr <= (o_grant_index == IDX_W'(NUM_REQS - 1)) ? '0 : o_grant_index + IDX_W'(1);
    end
  end

endmodule

// File: rtl/vx_fpu_rsp_arb.sv
// Merges NUM_INPUTS FPU response channels into one stream through a 2-entry FIFO.
// Input ready is derived only from FIFO occupancy and valids, so it never waits on rsp_out_ready.
module vx_fpu_rsp_arb
  import vx_fpu_rsp_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int NUM_LANES  = 1,
  parameter int TAG_WIDTH  = 1
) (
  input  logic            clk,
  input  logic            reset,
  vx_fpu_rsp_arb_if.slave rsp_if
);

  localparam int SEL_BITS      = sel_bits(NUM_INPUTS);
  localparam int TAG_OUT_WIDTH = TAG_WIDTH + SEL_BITS;
  localparam int IDX_W         = idx_width(NUM_INPUTS);

  typedef struct packed {
    logic [NUM_LANES-1:0][XLEN-1:0] result;
    fflags_t [NUM_LANES-1:0]        fflags;
    logic                           has_fflags;
    logic [TAG_OUT_WIDTH-1:0]       tag;
  } entry_t;

  entry_t                         r_mem [FIFO_DEPTH];
  logic                           r_head;
  logic                           r_tail;
  logic [1:0]                     r_count;

  logic                           w_enable;
  logic                           w_push;
  logic                           w_pop;
  logic [NUM_INPUTS-1:0]          w_grant_onehot;
  logic [IDX_W-1:0]               w_grant_index;
  logic                           w_grant_valid;
  logic [NUM_LANES-1:0][XLEN-1:0] w_sel_result;
  fflags_t [NUM_LANES-1:0]        w_sel_fflags;
  logic                           w_sel_has_fflags;
  logic [TAG_WIDTH-1:0]           w_sel_tag;
  logic [TAG_OUT_WIDTH-1:0]       w_push_tag;
  entry_t                         w_push_entry;
  entry_t                         w_head;

  assign w_enable = !reset && (r_count < 2'(FIFO_DEPTH));

  VX_rr_arbiter #(
    .NUM_REQS (NUM_INPUTS)
  ) u_arbiter (
    .clk            (clk),
    .reset          (reset),
    .i_requests     (rsp_if.rsp_in_valid),
    .i_enable       (w_enable),
    .o_grant_onehot (w_grant_onehot),
    .o_grant_index  (w_grant_index),
    .o_grant_valid  (w_grant_valid)
  );

  assign rsp_if.rsp_in_ready = w_grant_onehot;
  assign w_push = w_grant_valid;
  assign w_pop  = (r_count != 2'd0) && rsp_if.rsp_out_ready;

  always_comb begin
    w_sel_result     = '0;
    w_sel_fflags     = '0;
    w_sel_has_fflags = 1'b0;
    w_sel_tag        = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (w_grant_onehot[i]) begin
        w_sel_result     = rsp_if.rsp_in_result[i];
        w_sel_fflags     = rsp_if.rsp_in_fflags[i];
        w_sel_has_fflags = rsp_if.rsp_in_has_fflags[i];
        w_sel_tag        = rsp_if.rsp_in_tag[i];
      end
    end
  end

  // The source index rides in the low tag bits so completions can be routed back.
  generate
    if (NUM_INPUTS > 1) begin : g_tag_with_index
      assign w_push_tag = {w_sel_tag, w_grant_index};
    end else begin : g_tag_passthrough
      assign w_push_tag = w_sel_tag;
    end
  endgenerate

  assign w_push_entry = '{
    result:     w_sel_result,
    fflags:     w_sel_fflags,
    has_fflags: w_sel_has_fflags,
    tag:        w_push_tag
  };

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
    end else begin
      if (w_push) r_tail <= ~r_tail;
      if (w_pop)  r_head <= ~r_head;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage is left unreset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_push_entry;
  end

  assign w_head = r_mem[r_head];

  assign rsp_if.rsp_out_valid      = (r_count != 2'd0);
  assign rsp_if.rsp_out_result     = w_head.result;
  assign rsp_if.rsp_out_fflags     = w_head.fflags;
  assign rsp_if.rsp_out_has_fflags = w_head.has_fflags;
  assign rsp_if.rsp_out_tag        = w_head.tag;

endmodule
